// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the data-memory block RAM.
// Port 0 is the CPU M-stage data port and has priority; port 1 is the DMA/loader port.
// A run counter bounds how many CPU grants can pass a waiting DMA request.
// Read data comes back one cycle after the grant and is steered to the port that issued it.
module dm_port_arbiter #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned MAX_CPU_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,

    input  logic              dma_req,
    input  logic [3:0]        dma_be,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,

    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {StCpuPrio, StDmaTurn} state_e;
    typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} own_e;

    localparam logic [3:0] MaxRun = 4'(MAX_CPU_RUN);

    state_e     state_q, state_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    own_e       rd_own_q, rd_own_d;

    // Grants follow the current state; nothing is granted while reset is low so no write can leak.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (reset) begin
            if (state_q == StDmaTurn) begin
                dma_gnt = dma_req;
                cpu_gnt = cpu_req & ~dma_req;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req & ~cpu_req;
            end
        end
    end

    assign cpu_stall = reset & cpu_req & ~cpu_gnt;

    // Steer the granted port's payload to the RAM; idle cycles drive zeros.
    always_comb begin
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_be    = cpu_be;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_be    = dma_be;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // Next state: run counter, arbitration state and read-return owner.
    always_comb begin
        run_cnt_d = run_cnt_q;
        state_d   = state_q;
        rd_own_d  = OwnNone;

        // The counter only measures CPU grants that pass a waiting DMA request.
        if (!dma_req || dma_gnt) begin
            run_cnt_d = '0;
        end else if (cpu_gnt && (run_cnt_q < MaxRun)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end

        case (state_q)
            StCpuPrio: begin
                if (run_cnt_d == MaxRun) begin
                    state_d = StDmaTurn;
                end
            end
            StDmaTurn: begin
                if (dma_gnt || !dma_req) begin
                    state_d = StCpuPrio;
                end
            end
            default: state_d = StCpuPrio;
        endcase

        if (cpu_gnt && (cpu_be == 4'b0000)) begin
            rd_own_d = OwnCpu;
        end else if (dma_gnt && (dma_be == 4'b0000)) begin
            rd_own_d = OwnDma;
        end
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StCpuPrio;
            run_cnt_q <= '0;
            rd_own_q  <= OwnNone;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            rd_own_q  <= rd_own_d;
        end
    end

    // Return path: only the owner of last cycle's read sees the RAM data.
    always_comb begin
        cpu_rvalid = (rd_own_q == OwnCpu);
        dma_rvalid = (rd_own_q == OwnDma);
        cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
        dma_rdata  = dma_rvalid ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed vector table, hand-written reset sequences,
// and randomized traffic checked against a behavioural model with its own memory image.
module tb_dm_port_arbiter;

    localparam int AW   = 13;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, dma_req;
    logic [3:0]    cpu_be, dma_be;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [31:0]   cpu_wdata, dma_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0]   cpu_rdata, dma_rdata;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    dm_port_arbiter #(.ADDR_W(AW), .MAX_CPU_RUN(MAXR)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Read-first block RAM; cleared while reset is sampled low so every phase starts from zeros.
    logic [31:0] ram [1 << AW];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] eg, input logic es,
                           input logic ecrv, input logic [31:0] ecrd,
                           input logic edrv, input logic [31:0] edrd,
                           input logic [3:0] embe, input logic [AW-1:0] ema,
                           input logic [31:0] emw);
        chk({tag, " gnt"}, {30'd0, cpu_gnt, dma_gnt}, {30'd0, eg});
        chk({tag, " stall"}, {31'd0, cpu_stall}, {31'd0, es});
        chk({tag, " cpu_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, ecrv});
        chk({tag, " cpu_rdata"}, cpu_rdata, ecrd);
        chk({tag, " dma_rvalid"}, {31'd0, dma_rvalid}, {31'd0, edrv});
        chk({tag, " dma_rdata"}, dma_rdata, edrd);
        chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, embe});
        chk({tag, " mem_addr"}, {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, ema});
        chk({tag, " mem_wdata"}, mem_wdata, emw);
    endtask

    // Drive one cycle's inputs just after the falling edge, leaving time to settle before checks.
    task automatic drive(input logic r, input logic cr, input logic [3:0] cb,
                         input logic [AW-1:0] ca, input logic [31:0] cw,
                         input logic dr, input logic [3:0] db,
                         input logic [AW-1:0] da, input logic [31:0] dw);
        @(negedge clk);
        reset = r;
        cpu_req = cr; cpu_be = cb; cpu_addr = ca; cpu_wdata = cw;
        dma_req = dr; dma_be = db; dma_addr = da; dma_wdata = dw;
        #1;
    endtask

    typedef struct {
        logic cr; logic [3:0] cb; logic [AW-1:0] ca; logic [31:0] cw;
        logic dr; logic [3:0] db; logic [AW-1:0] da; logic [31:0] dw;
        logic [1:0] eg; logic es;
        logic ecrv; logic [31:0] ecrd; logic edrv; logic [31:0] edrd;
        logic [3:0] embe; logic [AW-1:0] ema; logic [31:0] emw;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic cr, input logic [3:0] cb, input int ca,
                                input logic [31:0] cw, input logic dr, input logic [3:0] db,
                                input int da, input logic [31:0] dw, input logic [1:0] eg,
                                input logic es, input logic ecrv, input logic [31:0] ecrd,
                                input logic edrv, input logic [31:0] edrd,
                                input logic [3:0] embe, input int ema, input logic [31:0] emw);
        vec_t v;
        v.cr = cr; v.cb = cb; v.ca = AW'(ca); v.cw = cw;
        v.dr = dr; v.db = db; v.da = AW'(da); v.dw = dw;
        v.eg = eg; v.es = es; v.ecrv = ecrv; v.ecrd = ecrd; v.edrv = edrv; v.edrd = edrd;
        v.embe = embe; v.ema = AW'(ema); v.emw = emw;
        vecs.push_back(v);
    endfunction

    // Behavioural model: DMA is owed a slot once MAXR CPU grants in a row have passed it.
    int          streak;
    int          pend;          // 0 none, 1 CPU, 2 DMA
    logic [31:0] pend_data;
    logic [31:0] ref_mem [1 << AW];
    logic        m_cg, m_dg;

    task automatic model_cycle(input int n);
        logic        cg, dg;
        logic [3:0]  be;
        logic [AW-1:0] a;
        logic [31:0] w;
        string       tag;
        tag = $sformatf("rnd%0d", n);
        if (!reset) begin
            chk_all(tag, 2'b00, 1'b0, 1'b0, 0, 1'b0, 0, 4'h0, '0, 0);
            streak = 0; pend = 0; m_cg = 1'b0; m_dg = 1'b0;
            for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
            return;
        end
        if (streak == MAXR) begin
            dg = dma_req; cg = cpu_req && !dma_req;
        end else begin
            cg = cpu_req; dg = dma_req && !cpu_req;
        end
        be = 4'h0; a = '0; w = '0;
        if (cg) begin be = cpu_be; a = cpu_addr; w = cpu_wdata; end
        else if (dg) begin be = dma_be; a = dma_addr; w = dma_wdata; end
        chk_all(tag, {cg, dg}, cpu_req && !cg, pend == 1, (pend == 1) ? pend_data : 0,
                pend == 2, (pend == 2) ? pend_data : 0, be, a, w);
        pend = 0;
        if (cg || dg) begin
            if (be == 4'h0) begin
                pend = cg ? 1 : 2;
                pend_data = ref_mem[a];
            end else begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = w[8*b +: 8];
            end
        end
        if (!dma_req || dg) streak = 0;
        else if (cg && streak < MAXR) streak++;
        m_cg = cg; m_dg = dg;
    endtask

    initial begin
        logic       cr, dr, rs;
        logic [3:0] cb, db;
        logic [AW-1:0] ca, da;
        logic [31:0] cw, dw;
        logic [1:0]  g;

        reset = 1'b1;
        cpu_req = 0; cpu_be = 0; cpu_addr = '0; cpu_wdata = 0;
        dma_req = 0; dma_be = 0; dma_addr = '0; dma_wdata = 0;
        #2 reset = 1'b0;

        // Reset held with both ports requesting: everything must stay quiet.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'h0, 13'd5, 0, 1'b1, 4'hF, 13'd5, 32'h12345678);
            chk_all($sformatf("rst_hold%0d", i), 2'b00, 1'b0, 1'b0, 0, 1'b0, 0, 4'h0, '0, 0);
        end

        // cr cb ca cw | dr db da dw | gnt stall | crv crd | drv drd | mem be addr wdata
        add(1, 0, 5, 0,            1, 4'hF, 5, 32'h12345678, 2'b10, 0, 0, 0, 0, 0, 0, 5, 0);
        add(0, 0, 0, 0,            1, 4'hF, 5, 32'h12345678, 2'b01, 0, 1, 0, 0, 0,
            4'hF, 5, 32'h12345678);
        add(0, 0, 0, 0,            1, 4'hF, 3, 32'h11223344, 2'b01, 0, 0, 0, 0, 0,
            4'hF, 3, 32'h11223344);
        add(1, 0, 5, 0,            0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 5, 0);
        add(0, 0, 0, 0,            0, 0, 0, 0, 2'b00, 0, 1, 32'h12345678, 0, 0, 0, 0, 0);
        add(1, 4'h4, 3, 32'hAAAAAAAA, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0,
            4'h4, 3, 32'hAAAAAAAA);
        add(1, 0, 3, 0,            0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 3, 0);
        add(0, 0, 0, 0,            1, 0, 5, 0, 2'b01, 0, 1, 32'h11AA3344, 0, 0, 0, 5, 0);
        add(1, 0, 3, 0,            0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 32'h12345678, 0, 3, 0);
        add(0, 0, 0, 0,            0, 0, 0, 0, 2'b00, 0, 1, 32'h11AA3344, 0, 0, 0, 0, 0);
        // Both ports streaming reads: C,C,C,C,D,C,C,C,C,D.
        add(1, 0, 3, 0,            1, 0, 5, 0, 2'b10, 0, 0, 0, 0, 0, 0, 3, 0);
        for (int k = 0; k < 3; k++)
            add(1, 0, 3, 0,        1, 0, 5, 0, 2'b10, 0, 1, 32'h11AA3344, 0, 0, 0, 3, 0);
        add(1, 0, 3, 0,            1, 0, 5, 0, 2'b01, 1, 1, 32'h11AA3344, 0, 0, 0, 5, 0);
        add(1, 0, 3, 0,            1, 0, 5, 0, 2'b10, 0, 0, 0, 1, 32'h12345678, 0, 3, 0);
        for (int k = 0; k < 3; k++)
            add(1, 0, 3, 0,        1, 0, 5, 0, 2'b10, 0, 1, 32'h11AA3344, 0, 0, 0, 3, 0);
        add(1, 0, 3, 0,            1, 0, 5, 0, 2'b01, 1, 1, 32'h11AA3344, 0, 0, 0, 5, 0);
        add(0, 0, 0, 0,            0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h12345678, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].cr, vecs[i].cb, vecs[i].ca, vecs[i].cw,
                  vecs[i].dr, vecs[i].db, vecs[i].da, vecs[i].dw);
            chk_all($sformatf("row%0d", i), vecs[i].eg, vecs[i].es, vecs[i].ecrv,
                    vecs[i].ecrd, vecs[i].edrv, vecs[i].edrd, vecs[i].embe, vecs[i].ema,
                    vecs[i].emw);
        end

        // Reset in the cycle after a read grant: the read is dropped and the run count restarts.
        drive(1'b1, 1'b1, 4'h0, 13'd3, 0, 1'b1, 4'h0, 13'd5, 0);
        chk("mid_a gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd2);
        drive(1'b1, 1'b1, 4'h0, 13'd3, 0, 1'b1, 4'h0, 13'd5, 0);
        chk("mid_b gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd2);
        chk("mid_b cpu_rdata", cpu_rdata, 32'h11AA3344);
        drive(1'b0, 1'b0, 4'h0, 13'd0, 0, 1'b0, 4'h0, 13'd0, 0);
        chk("mid_rst cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("mid_rst cpu_rdata", cpu_rdata, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 4'h0, 13'd3, 0, 1'b1, 4'h0, 13'd5, 0);
            g = (k == 4) ? 2'b01 : 2'b10;
            chk($sformatf("post_rst%0d gnt", k), {30'd0, cpu_gnt, dma_gnt}, {30'd0, g});
            chk($sformatf("post_rst%0d cpu_rvalid", k), {31'd0, cpu_rvalid},
                (k == 0) ? 32'd0 : 32'd1);
        end

        // Randomized traffic, starting from a reset cycle so the model is in step.
        cr = 0; dr = 0; cb = 0; db = 0; ca = '0; da = '0; cw = 0; dw = 0;
        m_cg = 0; m_dg = 0;
        drive(1'b0, 0, 0, '0, 0, 0, 0, '0, 0);
        model_cycle(-1);
        for (int n = 0; n < 600; n++) begin
            rs = ($urandom_range(0, 79) != 0);
            if (!cr || m_cg) begin
                cr = ($urandom_range(0, 9) < 7);
                cb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                ca = AW'($urandom_range(0, 15));
                cw = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                cr = 0;
            end
            if (!dr || m_dg) begin
                dr = ($urandom_range(0, 9) < 6);
                db = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                da = AW'($urandom_range(0, 15));
                dw = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                dr = 0;
            end
            drive(rs, cr, cb, ca, cw, dr, db, da, dw);
            model_cycle(n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
